mux_scan_sequencer: RTL
=======================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream/downstream companion of the 8:1 mux stage: drives its s0/s1/s2 selects
//   through all 8 channels and samples the mux output y after each select settles.
//   Assembles one 8-bit word per scan, presents it on data_out and pulses done.
//   Turns the combinational mux into a parallel-to-serial-to-parallel channel scanner.
// PARAMETERS
//   SETTLE_CYCLES  1  cycles a select is held before y_in is sampled; values <1 are treated as 1
// PORTS
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   start     in   1  scan request; accepted only in IDLE
//   y_in      in   1  mux output y
//   s0        out  1  mux select, MSB of channel index
//   s1        out  1  mux select, middle bit
//   s2        out  1  mux select, LSB of channel index
//   busy      out  1  high from start acceptance until DONE is left
//   done      out  1  one-cycle pulse: data_out just updated
//   data_out  out  8  last completed scan; bit k = value sampled on channel k
// BEHAVIOUR
//   - Channel index ch = {s0,s1,s2}; s0 is the MSB. ch=k selects mux input in_k.
//   - All outputs are registered.
//   - Reset values: s0=s1=s2=0, busy=0, done=0, data_out=8'h00; state IDLE; counters 0.
//   - States:
//       IDLE   : start=1 at edge E0 -> SETTLE; ch=0; busy=1; settle count loaded.
//       SETTLE : hold ch for SETTLE_CYCLES-1 edges, then -> SAMPLE.
//       SAMPLE : at the edge, y_in is captured into shadow bit ch.
//                If ch<7: ch++ and -> SETTLE.
//                If ch=7: -> DONE; data_out <= shadow including bit7; done=1.
//       DONE   : one cycle; next edge done=0, busy=0, ch=0, -> IDLE.
//   - Each select value is held exactly SETTLE_CYCLES+1 cycles; order is 0,1,...,7.
//   - Latency: data_out and done update at edge E0+8*(SETTLE_CYCLES+1).
//     With the default setting that is 16 edges after start was accepted.
//   - data_out changes only on entry to DONE. Partial scans never reach it.
//     data_out holds its value between scans.
//   - start while busy, including the DONE cycle, is ignored; no queueing.
//   - start held high in IDLE begins one scan per IDLE visit.
//   - rst mid-scan aborts immediately: all outputs and state return to reset values.
//     The shadow register is cleared and no done pulse is produced.
//   - y_in is assumed stable from the mux; no synchronizer is inside this block.
// CONFIGURATION
//   MUX_SCAN_CONTINUOUS_EN defined:
//     - DONE goes to SETTLE with ch=0 instead of IDLE; busy stays 1.
//     - Scans repeat back-to-back with done period 8*(SETTLE_CYCLES+1)+1 cycles.
//     - start is needed only for the first scan. Only rst halts scanning.
//   MUX_SCAN_CONTINUOUS_EN undefined:
//     - Single-shot per start, as described above.
// TESTING
//   1. Mux inputs 8'hA5, SETTLE_CYCLES=1, start pulse
//      -> done exactly 16 edges later, data_out=8'hA5, busy low the next cycle.
//   2. Select sequence, SETTLE_CYCLES=1
//      -> {s0,s1,s2} steps 000,001,...,111, each held 2 cycles, back to 000 in IDLE.
//   3. SETTLE_CYCLES=3, inputs 8'h3C
//      -> done at edge 32, data_out=8'h3C.
//      Change in_5 during ch5's hold before the sample edge -> new value captured.
//   4. Scan inputs 8'hFF, then rst at edge 5 of the next scan
//      -> all outputs reset, data_out=8'h00, no done.
//      Following start returns the correct word.
//   5. start pulses at edges 3 and 16 (the DONE cycle)
//      -> both ignored, exactly one done.
//      Then inputs 8'h5A with a fresh start -> data_out=8'h5A.
//   6. MUX_SCAN_CONTINUOUS_EN, inputs 8'hC3, one start
//      -> done at edges 16, 33, 50, busy stays 1.
//      Input change mid-run is reflected in the next full word only.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sequencer
//  Description : Steps an external 8:1 mux through channels 0..7, samples y_in
//                once per channel and publishes the assembled byte with a
//                one-cycle done pulse. The optional macro MUX_SCAN_CONTINUOUS_EN
//                turns single-shot scans into back-to-back repeating scans.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    // A request below one settle cycle still needs one cycle for the mux to settle.
    localparam int c_SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int c_CNT_W      = (c_SETTLE_EFF > 1) ? $clog2(c_SETTLE_EFF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_SETTLE_EFF - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [2:0]         ch_q,     ch_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic [6:0]         shadow_q, shadow_d;
    logic [7:0]         data_q,   data_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d  = c_ST_SETTLE;
                    ch_d     = 3'd0;
                    cnt_d    = c_CNT_LOAD;
                    shadow_d = 7'd0;
                    busy_d   = 1'b1;
                end
            end

            c_ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = c_ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            c_ST_SAMPLE: begin
                // Channel 7 goes straight to the output so the word lands on the DONE edge.
                if (ch_q == 3'd7) begin
                    state_d = c_ST_DONE;
                    data_d  = {y_in, shadow_q};
                    done_d  = 1'b1;
                end else begin
                    shadow_d[ch_q] = y_in;
                    ch_d           = ch_q + 3'd1;
                    cnt_d          = c_CNT_LOAD;
                    state_d        = c_ST_SETTLE;
                end
            end

            c_ST_DONE: begin
                ch_d     = 3'd0;
                shadow_d = 7'd0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                state_d  = c_ST_SETTLE;
                cnt_d    = c_CNT_LOAD;
`else
                state_d  = c_ST_IDLE;
                busy_d   = 1'b0;
`endif
            end

            default: begin
                state_d = c_ST_IDLE;
                ch_d    = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            ch_q     <= 3'd0;
            cnt_q    <= '0;
            shadow_q <= 7'd0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Channel index is {s0,s1,s2} with s0 as the MSB.
    assign s0       = ch_q[2];
    assign s1       = ch_q[1];
    assign s2       = ch_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule
`default_nettype wire
